// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage. Owns the architectural PC, fetches
//             from instruction memory over a valid/ready request and valid
//             response interface, and loads the IF/ID pipeline register with
//             stall (hazard unit) and squash (control-flow redirect) support.
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        redirect,
  input  logic        stall_d,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pc_out,
  output logic [31:0] pc_d,
  output logic [31:0] inst_d,
  output logic        valid_d
);

  // Fetch controller states; at most one request is ever outstanding.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a request for r_pc
    S_WAIT = 2'd1,  // request accepted, waiting for its response
    S_HOLD = 2'd2   // response captured while IF/ID is stalled
  } state_t;

  // Fetch-side state
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;       // outstanding response belongs to a squashed path
  logic [31:0] r_hold;       // instruction parked while the decode stage stalls

  // IF/ID pipeline register
  logic [31:0] r_pc_d;
  logic [31:0] r_inst_d;
  logic        r_valid_d;

  // Next-state values
  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_drop_nxt;
  logic [31:0] w_hold_nxt;
  logic        w_fire;
  logic        w_deliver;    // an instruction enters IF/ID this cycle
  logic [31:0] w_deliver_inst;

  logic [31:0] w_pc_d_nxt;
  logic [31:0] w_inst_d_nxt;
  logic        w_valid_d_nxt;

  // Request is only presented in S_REQ and its address is always the PC.
  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign w_fire         = imem_req_valid & imem_req_ready;

  assign pc_out  = r_pc;
  assign pc_d    = r_pc_d;
  assign inst_d  = r_inst_d;
  assign valid_d = r_valid_d;

  // Fetch FSM next-state, PC and hold-buffer logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_drop_nxt     = r_drop;
    w_hold_nxt     = r_hold;
    w_deliver      = 1'b0;
    w_deliver_inst = r_hold;

    case (r_state)
      S_REQ: begin
        // Responses seen here have no outstanding request and are ignored.
        if (redirect) begin
          w_pc_nxt = pc_in;
        end
        if (w_fire) begin
          w_state_nxt = S_WAIT;
          // A request accepted in the redirect cycle fetched the wrong path.
          w_drop_nxt  = redirect;
        end
      end

      S_WAIT: begin
        if (redirect) begin
          w_pc_nxt   = pc_in;
          w_drop_nxt = 1'b1;
        end
        if (imem_rsp_valid) begin
          if (r_drop || redirect) begin
            // Wrong-path data: throw it away and refetch from the new PC.
            w_drop_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (!stall_d) begin
            w_deliver      = 1'b1;
            w_deliver_inst = imem_rsp_data;
            w_pc_nxt       = pc_in;
            w_state_nxt    = S_REQ;
          end else begin
            w_hold_nxt  = imem_rsp_data;
            w_state_nxt = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          // Parked instruction is on the wrong path; squash it.
          w_pc_nxt    = pc_in;
          w_hold_nxt  = 32'h0;
          w_state_nxt = S_REQ;
        end else if (!stall_d) begin
          w_deliver      = 1'b1;
          w_deliver_inst = r_hold;
          w_pc_nxt       = pc_in;
          w_hold_nxt     = 32'h0;
          w_state_nxt    = S_REQ;
        end
      end

      default: begin
        w_state_nxt = S_REQ;
        w_drop_nxt  = 1'b0;
      end
    endcase
  end

  // IF/ID update: redirect squashes, stall holds, otherwise load or bubble.
  always_comb begin
    w_pc_d_nxt    = r_pc_d;
    w_inst_d_nxt  = r_inst_d;
    w_valid_d_nxt = r_valid_d;

    if (redirect) begin
      w_valid_d_nxt = 1'b0;
      w_inst_d_nxt  = NOP_INST;
    end else if (stall_d) begin
      w_valid_d_nxt = r_valid_d;
    end else if (w_deliver) begin
      // The PC register still names the instruction being delivered.
      w_pc_d_nxt    = r_pc;
      w_inst_d_nxt  = w_deliver_inst;
      w_valid_d_nxt = 1'b1;
    end else begin
      w_valid_d_nxt = 1'b0;
      w_inst_d_nxt  = NOP_INST;
    end
  end

  // Fetch-side state registers; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_hold  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_drop  <= w_drop_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc_d    <= 32'h0;
      r_inst_d  <= NOP_INST;
      r_valid_d <= 1'b0;
    end else begin
      r_pc_d    <= w_pc_d_nxt;
      r_inst_d  <= w_inst_d_nxt;
      r_valid_d <= w_valid_d_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Directed self-checking bench for if_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        redirect;
  logic        stall_d;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pc_out;
  logic [31:0] pc_d;
  logic [31:0] inst_d;
  logic        valid_d;

  int n_checks = 0;
  int n_fail   = 0;

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (C_NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .redirect       (redirect),
    .stall_d        (stall_d),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_out         (pc_out),
    .pc_d           (pc_d),
    .inst_d         (inst_d),
    .valid_d        (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    pc_in          = 32'h0;
    redirect       = 1'b0;
    stall_d        = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // ---------------- reset state ----------------
    #2;
    chk("rst_pc_out",    pc_out, 32'h0);
    chk("rst_valid_d",   {31'h0, valid_d}, 32'h0);
    chk("rst_inst_d",    inst_d, C_NOP);
    chk("rst_pc_d",      pc_d, 32'h0);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h1);
    #10;
    rst = 1'b0;

    // ---------------- sequential fetch ----------------
    imem_req_ready = 1'b1;
    pc_in = 32'h4;
    chk("seq_addr0", imem_req_addr, 32'h0);
    step();                                   // request for 0x0 accepted
    chk("seq_wait_noreq", {31'h0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    step();                                   // delivered
    chk("seq_valid0", {31'h0, valid_d}, 32'h1);
    chk("seq_pcd0",   pc_d,   32'h0);
    chk("seq_inst0",  inst_d, 32'h0010_0093);
    chk("seq_addr1",  imem_req_addr, 32'h4);
    imem_rsp_valid = 1'b0; pc_in = 32'h8;
    step();                                   // request for 0x4 accepted
    chk("seq_bubble", {31'h0, valid_d}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;
    step();
    chk("seq_pcd1",   pc_d,   32'h4);
    chk("seq_inst1",  inst_d, 32'h0020_0113);
    chk("seq_valid1", {31'h0, valid_d}, 32'h1);
    chk("seq_addr2",  imem_req_addr, 32'h8);
    imem_rsp_valid = 1'b0;

    // ---------------- redirect in S_WAIT ----------------
    step();                                   // request for 0x8 accepted
    redirect = 1'b1; pc_in = 32'h100;
    step();
    chk("rdw_pc_out", pc_out, 32'h100);
    chk("rdw_valid",  {31'h0, valid_d}, 32'h0);
    redirect = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0_BAD0;
    step();                                   // stale response for 0x8 dropped
    chk("rdw_drop_valid", {31'h0, valid_d}, 32'h0);
    chk("rdw_drop_inst",  inst_d, C_NOP);
    chk("rdw_req_valid",  {31'h0, imem_req_valid}, 32'h1);
    chk("rdw_req_addr",   imem_req_addr, 32'h100);
    imem_rsp_valid = 1'b0; pc_in = 32'h104;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0030_0193;
    step();
    chk("rdw_pcd",    pc_d,   32'h100);
    chk("rdw_inst",   inst_d, 32'h0030_0193);
    chk("rdw_pc_nxt", pc_out, 32'h104);
    imem_rsp_valid = 1'b0;

    // ---------------- stall during response ----------------
    imem_req_ready = 1'b0; redirect = 1'b1; pc_in = 32'h20;
    step();                                   // redirect without fire
    chk("stl_addr", imem_req_addr, 32'h20);
    redirect = 1'b0; imem_req_ready = 1'b1; pc_in = 32'h24;
    step();                                   // request for 0x20 accepted
    stall_d = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();                                   // parked in hold buffer
    imem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_noreq",  {31'h0, imem_req_valid}, 32'h0);
      chk("stl_pc_out", pc_out, 32'h20);
      chk("stl_pcd",    pc_d,   32'h100);
      chk("stl_valid",  {31'h0, valid_d}, 32'h0);
      if (i < 2) step();
    end
    stall_d = 1'b0;
    step();
    chk("stl_rel_pcd",   pc_d,   32'h20);
    chk("stl_rel_inst",  inst_d, 32'hDEAD_BEEF);
    chk("stl_rel_valid", {31'h0, valid_d}, 32'h1);
    chk("stl_rel_addr",  imem_req_addr, 32'h24);

    // ---------------- back-pressure ----------------
    imem_req_ready = 1'b0; redirect = 1'b1; pc_in = 32'h40;
    step();
    redirect = 1'b0; pc_in = 32'h44;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_req_valid", {31'h0, imem_req_valid}, 32'h1);
      chk("bp_addr",      imem_req_addr, 32'h40);
      chk("bp_bubble",    {31'h0, valid_d}, 32'h0);
    end
    imem_req_ready = 1'b1;
    step();                                   // accepted on fifth cycle
    chk("bp_accept", {31'h0, imem_req_valid}, 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0040_0213;
    step();
    chk("bp_pcd",  pc_d,   32'h40);
    chk("bp_inst", inst_d, 32'h0040_0213);
    imem_rsp_valid = 1'b0;

    // ---------------- redirect in S_HOLD ----------------
    pc_in = 32'h48;
    step();                                   // request for 0x44 accepted
    stall_d = 1'b1; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    step();                                   // parked
    imem_rsp_valid = 1'b0; redirect = 1'b1; pc_in = 32'h200;
    step();
    chk("rdh_valid",     {31'h0, valid_d}, 32'h0);
    chk("rdh_inst",      inst_d, C_NOP);
    chk("rdh_req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rdh_addr",      imem_req_addr, 32'h200);
    redirect = 1'b0; stall_d = 1'b0; pc_in = 32'h204;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0293;
    step();
    chk("rdh_pcd",  pc_d,   32'h200);
    chk("rdh_inst2", inst_d, 32'h0050_0293);
    imem_rsp_valid = 1'b0;

    // ---------------- async reset mid-S_WAIT ----------------
    stall_d = 1'b1; pc_in = 32'h208;
    step();                                   // request accepted, IF/ID held
    chk("ar_pre_valid", {31'h0, valid_d}, 32'h1);
    chk("ar_pre_wait",  {31'h0, imem_req_valid}, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_pc_out", pc_out, 32'h0);
    chk("ar_valid",  {31'h0, valid_d}, 32'h0);
    chk("ar_inst",   inst_d, C_NOP);
    chk("ar_pcd",    pc_d,   32'h0);
    chk("ar_req",    {31'h0, imem_req_valid}, 32'h1);
    #3;
    rst = 1'b0; stall_d = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00;
    step();                                   // late response ignored
    chk("ar_late_req",   {31'h0, imem_req_valid}, 32'h1);
    chk("ar_late_addr",  imem_req_addr, 32'h0);
    chk("ar_late_valid", {31'h0, valid_d}, 32'h0);
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1; pc_in = 32'h4;
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    step();
    chk("ar_fresh_valid", {31'h0, valid_d}, 32'h1);
    chk("ar_fresh_pcd",   pc_d,   32'h0);
    chk("ar_fresh_inst",  inst_d, 32'h0010_0093);
    chk("ar_fresh_pc",    pc_out, 32'h4);
    imem_rsp_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage that sits directly downstream of the next-PC selection logic. It holds the architectural PC register and drives `pc_out` back to the next-PC mux. It fetches from instruction memory over a valid/ready request plus valid response interface. It loads the IF/ID pipeline register, with stall from the hazard unit and flush on control-flow redirect (branch, JAL, JALR, EPC).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INST, 32'h0000_0013, instruction placed in inst_d when IF/ID is invalid (addi x0,x0,0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
pc_in  input  32  next PC from next-PC mux (pc_out+4, or redirect target when redirect=1).
redirect  input  1  one-cycle pulse: pc_in is a non-sequential target; squash wrong-path fetch.
stall_d  input  1  hazard unit: hold IF/ID and PC.
imem_req_valid  output  1  fetch request valid.
imem_req_addr  output  32  fetch address (= pc_out).
imem_req_ready  input  1  memory accepts request this cycle.
imem_rsp_valid  input  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance).
imem_rsp_data  input  32  fetched instruction.
pc_out  output  32  current PC register, to next-PC mux.
pc_d  output  32  IF/ID: PC of instruction.
inst_d  output  32  IF/ID: instruction.
valid_d  output  1  IF/ID entry valid.

Behaviour:
- Reset (async, on rst=1): pc_out=RESET_PC, state=S_REQ, drop=0, valid_d=0, inst_d=NOP_INST, pc_d=0, hold buffer cleared. Reset mid-transaction abandons the outstanding request; any response arriving after reset release while in S_REQ is ignored.
- States: S_REQ, S_WAIT, S_HOLD. At most one outstanding request.
- S_REQ:
  - imem_req_valid=1, addr=pc_out.
  - Fire (valid&ready) → S_WAIT.
  - redirect with no fire: pc_out<=pc_in, stay S_REQ. The address changes only on redirect.
  - redirect with fire in the same cycle: pc_out<=pc_in, drop<=1, → S_WAIT.
- S_WAIT:
  - imem_req_valid=0.
  - redirect: pc_out<=pc_in, drop<=1.
  - rsp_valid with drop=1 (or redirect same cycle): discard data, drop<=0, → S_REQ.
  - rsp_valid, no drop, stall_d=0: pc_d<=pc_out, inst_d<=data, valid_d<=1, pc_out<=pc_in, → S_REQ.
  - rsp_valid, no drop, stall_d=1: data into hold buffer, → S_HOLD.
- S_HOLD:
  - imem_req_valid=0.
  - stall_d=0: IF/ID<=hold buffer (pc_out, data), valid_d<=1, pc_out<=pc_in, → S_REQ.
  - redirect: discard hold buffer, pc_out<=pc_in, → S_REQ.
- IF/ID update rules:
  - redirect=1 → valid_d<=0 and inst_d<=NOP_INST (squash). Redirect has priority over stall_d.
  - stall_d=1 (no redirect) → IF/ID holds.
  - Otherwise, a cycle with no new instruction loaded → valid_d<=0, inst_d<=NOP_INST (bubble).
- PC update rules:
  - pc_out changes only on redirect or on instruction delivery to IF/ID. It never changes while stall_d=1 without redirect.
  - pc_in is consumed only on those edges.
  - Arithmetic is 32-bit wrap: 0xFFFF_FFFC+4 → 0x0000_0000; no special handling.
- Throughput: one instruction per 2 cycles with zero-wait memory (ready=1, response next cycle).
- Memory responding with rsp_valid while no request is outstanding is a protocol error; it is ignored in S_REQ.

Test Plan:
- Reset then sequential fetch, RESET_PC=0, ready=1, 1-cycle response, rsp data 0x00100093/0x00200113:
  - Expected: req addrs 0x0, 0x4, 0x8.
  - Expected: valid_d pulses with (pc_d,inst_d)=(0x0,0x00100093), (0x4,0x00200113).
- Redirect in S_WAIT: pc_out=0x8 request in flight, redirect=1 with pc_in=0x100:
  - Expected: response for 0x8 discarded, valid_d=0.
  - Expected: next req addr=0x100, then IF/ID gets pc_d=0x100.
- Stall during response: stall_d=1 when rsp 0xDEADBEEF arrives for pc 0x20, held 3 cycles:
  - Expected: IF/ID unchanged, no request issued during the stall, pc_out=0x20.
  - Expected: one cycle after release, pc_d=0x20, inst_d=0xDEADBEEF, next req 0x24.
- Back-pressure: imem_req_ready=0 for 4 cycles at pc 0x40:
  - Expected: req_valid held 1, addr stable 0x40, valid_d=0 bubbles.
  - Expected: acceptance on cycle 5.
- Redirect while stalled in S_HOLD with pc_in=0x200:
  - Expected: hold buffer discarded, valid_d=0, next req addr=0x200.
- Async reset asserted mid-S_WAIT, late response arriving after release:
  - Expected: immediately pc_out=RESET_PC, valid_d=0, inst_d=0x00000013.
  - Expected: late response ignored, fresh req at RESET_PC.
